// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I integer decode stage.
// Decodes OP, OP-IMM, BRANCH, LUI, AUIPC, JAL and JALR into ALU/branch
// controls with sign-extended immediates, behind a one-entry valid/ready
// register that supports hold, drain and flush.
module rv_decode_stage #(
  parameter int XLEN        = 32,
  parameter bit ILLEGAL_NOP = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_use_imm,
  output logic            out_use_pc,
  output logic            out_branch,
  output logic [2:0]      out_cond,
  output logic [1:0]      out_jump,
  output logic            out_illegal,
  output logic            out_trap
);

  // Major opcodes, insn[6:2]
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  // ALU operation codes seen by execute
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JAL  = 2'b01;
  localparam logic [1:0] JMP_JALR = 2'b10;

  // Widen a 32-bit signed immediate to the datapath width.
  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] imm_i(input logic [31:0] w);
    return sext32({{20{w[31]}}, w[31:20]});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [31:0] w);
    return sext32({{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_u(input logic [31:0] w);
    return sext32({w[31:12], 12'h000});
  endfunction

  function automatic logic signed [XLEN-1:0] imm_j(input logic [31:0] w);
    return sext32({{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0});
  endfunction

  // Base ALU op selected by funct3 when funct7 carries no modifier.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Instruction fields
  logic [4:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] fld_rs1;
  logic [4:0] fld_rs2;
  logic [4:0] fld_rd;

  assign opc     = in_insn[6:2];
  assign funct3  = in_insn[14:12];
  assign funct7  = in_insn[31:25];
  assign fld_rs1 = in_insn[19:15];
  assign fld_rs2 = in_insn[24:20];
  assign fld_rd  = in_insn[11:7];

  // Combinational decode of the incoming instruction
  logic                   ill_p0;
  logic [4:0]             rs1_p0;
  logic [4:0]             rs2_p0;
  logic [4:0]             rd_p0;
  logic                   rd_we_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [3:0]             alu_op_p0;
  logic                   use_imm_p0;
  logic                   use_pc_p0;
  logic                   branch_p0;
  logic [2:0]             cond_p0;
  logic [1:0]             jump_p0;

  // Upper immediate bits that qualify a shift-immediate. With a 64-bit
  // datapath imm[5] is the top shamt bit, so only imm[11:6] is checked.
  logic shamt_hi_zero;
  logic shamt_hi_sra;

  // Shift-immediate qualifier, width dependent
  always_comb begin
    shamt_hi_zero = 1'b0;
    shamt_hi_sra  = 1'b0;
    if (XLEN == 64) begin
      shamt_hi_zero = (in_insn[31:26] == 6'b000000);
      shamt_hi_sra  = (in_insn[31:26] == 6'b010000);
    end else begin
      shamt_hi_zero = (in_insn[31:25] == 7'b0000000);
      shamt_hi_sra  = (in_insn[31:25] == 7'b0100000);
    end
  end

  // Opcode decode; an illegal encoding collapses to a NOP-like bundle
  always_comb begin
    ill_p0     = 1'b0;
    rs1_p0     = 5'd0;
    rs2_p0     = 5'd0;
    rd_p0      = 5'd0;
    rd_we_p0   = 1'b0;
    imm_p0     = '0;
    alu_op_p0  = ALU_ADD;
    use_imm_p0 = 1'b0;
    use_pc_p0  = 1'b0;
    branch_p0  = 1'b0;
    cond_p0    = 3'b000;
    jump_p0    = JMP_NONE;

    if (in_insn[1:0] != 2'b11) begin
      ill_p0 = 1'b1;
    end else begin
      case (opc)
        OPC_OP: begin
          rs1_p0   = fld_rs1;
          rs2_p0   = fld_rs2;
          rd_p0    = fld_rd;
          rd_we_p0 = 1'b1;
          if (funct7 == 7'b0000000) begin
            alu_op_p0 = base_alu(funct3);
          end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
            alu_op_p0 = ALU_SUB;
          end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
            alu_op_p0 = ALU_SRA;
          end else begin
            ill_p0 = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          rs1_p0     = fld_rs1;
          rd_p0      = fld_rd;
          rd_we_p0   = 1'b1;
          use_imm_p0 = 1'b1;
          imm_p0     = imm_i(in_insn);
          alu_op_p0  = base_alu(funct3);
          if (funct3 == 3'b001 && !shamt_hi_zero) begin
            ill_p0 = 1'b1;
          end else if (funct3 == 3'b101) begin
            if (shamt_hi_sra) begin
              alu_op_p0 = ALU_SRA;
            end else if (!shamt_hi_zero) begin
              ill_p0 = 1'b1;
            end
          end
        end
        OPC_BRANCH: begin
          rs1_p0    = fld_rs1;
          rs2_p0    = fld_rs2;
          imm_p0    = imm_b(in_insn);
          alu_op_p0 = ALU_SUB;
          branch_p0 = 1'b1;
          cond_p0   = funct3;
          if (funct3 == 3'b010 || funct3 == 3'b011) begin
            ill_p0 = 1'b1;
          end
        end
        OPC_LUI: begin
          rd_p0      = fld_rd;
          rd_we_p0   = 1'b1;
          use_imm_p0 = 1'b1;
          imm_p0     = imm_u(in_insn);
          alu_op_p0  = ALU_PASSB;
        end
        OPC_AUIPC: begin
          rd_p0      = fld_rd;
          rd_we_p0   = 1'b1;
          use_imm_p0 = 1'b1;
          use_pc_p0  = 1'b1;
          imm_p0     = imm_u(in_insn);
          alu_op_p0  = ALU_ADD;
        end
        OPC_JAL: begin
          // Link value pc+4 is formed in execute; operand A is the pc.
          rd_p0     = fld_rd;
          rd_we_p0  = 1'b1;
          use_pc_p0 = 1'b1;
          imm_p0    = imm_j(in_insn);
          jump_p0   = JMP_JAL;
        end
        OPC_JALR: begin
          rs1_p0    = fld_rs1;
          rd_p0     = fld_rd;
          rd_we_p0  = 1'b1;
          use_pc_p0 = 1'b1;
          imm_p0    = imm_i(in_insn);
          jump_p0   = JMP_JALR;
          if (funct3 != 3'b000) begin
            ill_p0 = 1'b1;
          end
        end
        default: ill_p0 = 1'b1;
      endcase
    end

    // x0 is never written, so the write enable must not claim it.
    if (rd_p0 == 5'd0) begin
      rd_we_p0 = 1'b0;
    end

    // Illegal bundles carry only the illegal/trap flags.
    if (ill_p0) begin
      rs1_p0     = 5'd0;
      rs2_p0     = 5'd0;
      rd_p0      = 5'd0;
      rd_we_p0   = 1'b0;
      imm_p0     = '0;
      alu_op_p0  = ALU_ADD;
      use_imm_p0 = 1'b0;
      use_pc_p0  = 1'b0;
      branch_p0  = 1'b0;
      cond_p0    = 3'b000;
      jump_p0    = JMP_NONE;
    end
  end

  // ---- stage boundary: decode -> output register ----
  logic                   vld_p1;
  logic [XLEN-1:0]        pc_p1;
  logic [4:0]             rs1_p1;
  logic [4:0]             rs2_p1;
  logic [4:0]             rd_p1;
  logic                   rd_we_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic [3:0]             alu_op_p1;
  logic                   use_imm_p1;
  logic                   use_pc_p1;
  logic                   branch_p1;
  logic [2:0]             cond_p1;
  logic [1:0]             jump_p1;
  logic                   ill_p1;
  logic                   trap_p1;

  logic accept;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // One-entry pipeline register: reset, then flush, then accept/drain
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      pc_p1      <= '0;
      rs1_p1     <= 5'd0;
      rs2_p1     <= 5'd0;
      rd_p1      <= 5'd0;
      rd_we_p1   <= 1'b0;
      imm_p1     <= '0;
      alu_op_p1  <= ALU_ADD;
      use_imm_p1 <= 1'b0;
      use_pc_p1  <= 1'b0;
      branch_p1  <= 1'b0;
      cond_p1    <= 3'b000;
      jump_p1    <= JMP_NONE;
      ill_p1     <= 1'b0;
      trap_p1    <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      pc_p1      <= in_pc;
      rs1_p1     <= rs1_p0;
      rs2_p1     <= rs2_p0;
      rd_p1      <= rd_p0;
      rd_we_p1   <= rd_we_p0;
      imm_p1     <= imm_p0;
      alu_op_p1  <= alu_op_p0;
      use_imm_p1 <= use_imm_p0;
      use_pc_p1  <= use_pc_p0;
      branch_p1  <= branch_p0;
      cond_p1    <= cond_p0;
      jump_p1    <= jump_p0;
      ill_p1     <= ill_p0;
      trap_p1    <= ill_p0 && !ILLEGAL_NOP;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_rs1     = rs1_p1;
  assign out_rs2     = rs2_p1;
  assign out_rd      = rd_p1;
  assign out_rd_we   = rd_we_p1;
  assign out_imm     = imm_p1;
  assign out_alu_op  = alu_op_p1;
  assign out_use_imm = use_imm_p1;
  assign out_use_pc  = use_pc_p1;
  assign out_branch  = branch_p1;
  assign out_cond    = cond_p1;
  assign out_jump    = jump_p1;
  assign out_illegal = ill_p1;
  assign out_trap    = trap_p1;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage: directed decode cases plus a randomized
// handshake stream checked against a behavioural RV32I decode model.
module tb_rv_decode_stage;

  localparam int XLEN           = 32;
  localparam bit TB_ILLEGAL_NOP = 1'b0;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic            out_use_imm;
  logic            out_use_pc;
  logic            out_branch;
  logic [2:0]      out_cond;
  logic [1:0]      out_jump;
  logic            out_illegal;
  logic            out_trap;

  rv_decode_stage #(.XLEN(XLEN), .ILLEGAL_NOP(TB_ILLEGAL_NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_use_imm(out_use_imm),
    .out_use_pc(out_use_pc), .out_branch(out_branch), .out_cond(out_cond),
    .out_jump(out_jump), .out_illegal(out_illegal), .out_trap(out_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic        trap;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        ui;
    logic        up;
    logic        br;
    logic [2:0]  cond;
    logic [1:0]  jmp;
    logic [31:0] pc;
  } bundle_t;

  bundle_t got;
  assign got = {out_illegal, out_trap, out_rs1, out_rs2, out_rd, out_rd_we, out_imm,
                out_alu_op, out_use_imm, out_use_pc, out_branch, out_cond, out_jump, out_pc};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural decode model: immediates computed by place-value arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t    e;
    logic [3:0] op_tab [8];
    logic [2:0] f3;
    logic [6:0] f7;
    int         v_i, v_b, v_j;
    bit         legal;
    op_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    e = '0;
    e.pc = pc;
    f3 = w[14:12];
    f7 = w[31:25];
    v_i = int'(w[31:20]) - (w[31] ? 4096 : 0);
    v_b = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - (w[31] ? 4096 : 0);
    v_j = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
          - (w[31] ? (1 << 20) : 0);
    legal = 1'b1;
    if (w[1:0] != 2'b11) legal = 1'b0;
    else begin
      case (w[6:0])
        7'h33: begin
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.we = 1'b1;
          if (f7 == 7'h00) e.op = op_tab[f3];
          else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'd1;
          else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'd7;
          else legal = 1'b0;
        end
        7'h13: begin
          e.rs1 = w[19:15]; e.rd = w[11:7]; e.we = 1'b1; e.ui = 1'b1;
          e.imm = 32'(v_i); e.op = op_tab[f3];
          if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
          if (f3 == 3'd5) begin
            if (f7 == 7'h20) e.op = 4'd7;
            else if (f7 != 7'h00) legal = 1'b0;
          end
        end
        7'h63: begin
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'(v_b);
          e.op = 4'd1; e.br = 1'b1; e.cond = f3;
          if (f3 == 3'd2 || f3 == 3'd3) legal = 1'b0;
        end
        7'h37: begin
          e.rd = w[11:7]; e.we = 1'b1; e.ui = 1'b1; e.op = 4'd10;
          e.imm = {w[31:12], 12'h000};
        end
        7'h17: begin
          e.rd = w[11:7]; e.we = 1'b1; e.ui = 1'b1; e.up = 1'b1;
          e.imm = {w[31:12], 12'h000};
        end
        7'h6F: begin
          e.rd = w[11:7]; e.we = 1'b1; e.up = 1'b1; e.imm = 32'(v_j); e.jmp = 2'b01;
        end
        7'h67: begin
          e.rs1 = w[19:15]; e.rd = w[11:7]; e.we = 1'b1; e.up = 1'b1;
          e.imm = 32'(v_i); e.jmp = 2'b10;
          if (f3 != 3'd0) legal = 1'b0;
        end
        default: legal = 1'b0;
      endcase
    end
    if (e.rd == 5'd0) e.we = 1'b0;
    if (!legal) begin
      e = '0;
      e.pc = pc;
      e.ill = 1'b1;
      e.trap = !TB_ILLEGAL_NOP;
    end
    return e;
  endfunction

  // Random instruction biased toward the decoded opcode groups and edge funct7 values.
  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    logic [6:0]  opcs [7];
    logic [6:0]  f7s  [3];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom;
    f7s = '{7'h00, 7'h20, w[31:25]};
    k = int'($urandom_range(0, 11));
    if (k <= 6) w[6:0] = opcs[k];
    else if (k <= 8) begin
      w[6:0] = (k == 7) ? 7'h33 : 7'h13;
      w[31:25] = f7s[$urandom_range(0, 2)];
    end else if (k <= 10) begin
      w[6:0] = 7'h13;
      w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd1;
      w[31:25] = f7s[$urandom_range(0, 2)];
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_insn   = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 32'h40208133, 32'h0000_0010, 1'b1, 1'b0);
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if (got !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", got);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_alu_ops();
    bundle_t e;
    // sub x2,x1,x2
    drive(1'b1, 32'h40208133, 32'h0000_0040, 1'b1, 1'b0);
    step();
    e = '0; e.rs1 = 5'd1; e.rs2 = 5'd2; e.rd = 5'd2; e.we = 1'b1; e.op = 4'd1; e.pc = 32'h40;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL sub: valid %b got %h want %h", out_valid, got, e);
    end
    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h0000_0044, 1'b1, 1'b0);
    step();
    e = '0; e.rd = 5'd1; e.we = 1'b1; e.imm = 32'hFFFF_FFFF; e.ui = 1'b1; e.pc = 32'h44;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL addi_neg: valid %b got %h want %h", out_valid, got, e);
    end
    // srai x1,x1,1
    drive(1'b1, 32'h4010D093, 32'h0000_0048, 1'b1, 1'b0);
    step();
    e = '0; e.rs1 = 5'd1; e.rd = 5'd1; e.we = 1'b1; e.imm = 32'h0000_0401;
    e.ui = 1'b1; e.op = 4'd7; e.pc = 32'h48;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL srai: valid %b got %h want %h", out_valid, got, e);
    end
    // drain
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain: valid %b want 0", out_valid);
    end
  endtask

  task automatic test_branch();
    bundle_t e;
    // bne x1,x2,-4
    drive(1'b1, 32'hFE209EE3, 32'h0000_0080, 1'b1, 1'b0);
    step();
    e = '0; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'hFFFF_FFFC; e.op = 4'd1;
    e.br = 1'b1; e.cond = 3'b001; e.pc = 32'h80;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL bne: valid %b got %h want %h", out_valid, got, e);
    end
    // funct3 010 in a branch is reserved
    drive(1'b1, 32'hFE20AEE3, 32'h0000_0084, 1'b1, 1'b0);
    step();
    e = '0; e.ill = 1'b1; e.trap = !TB_ILLEGAL_NOP; e.pc = 32'h84;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL branch_illegal: valid %b got %h want %h", out_valid, got, e);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    bundle_t ea, eb;
    ea = ref_decode(32'h06430293, 32'h200);
    eb = ref_decode(32'h00C58533, 32'h204);
    drive(1'b1, 32'h06430293, 32'h200, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h00C58533, 32'h204, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== ea) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid %b ready %b got %h want %h", c, out_valid, in_ready, got, ea);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b want 1", in_ready);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || got !== eb) begin
      n_fail++; $display("FAIL after_release: valid %b got %h want %h", out_valid, got, eb);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL no_duplicate: valid %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h06430293, 32'h300, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h00C58533, 32'h304, 1'b0, 1'b1);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_discard: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    bundle_t e;
    drive(1'b1, 32'h06430293, 32'h400, 1'b1, 1'b0);
    step();
    drive(1'b1, 32'h00C58533, 32'h404, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || got !== '0) begin
      n_fail++; $display("FAIL mid_reset: valid %b got %h want 0", out_valid, got);
    end
    reset = 1'b0;
    // auipc x1,1 at pc 0x100
    drive(1'b1, 32'h00001097, 32'h100, 1'b1, 1'b0);
    step();
    e = '0; e.rd = 5'd1; e.we = 1'b1; e.imm = 32'h0000_1000; e.ui = 1'b1; e.up = 1'b1;
    e.pc = 32'h100;
    n_checks++;
    if (out_valid !== 1'b1 || got !== e) begin
      n_fail++; $display("FAIL auipc: valid %b got %h want %h", out_valid, got, e);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_random_stream();
    bundle_t     held;
    bit          mvld;
    bit          v, ordy, fl;
    logic [31:0] w, pc;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    mvld = 1'b0;
    held = '0;
    pc   = 32'h1000;
    for (int i = 0; i < 800; i++) begin
      n_checks++;
      if (out_valid !== mvld || (mvld && got !== held)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: valid %b got %h want valid %b %h", i, out_valid, got, mvld, held);
      end
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      w    = rand_insn();
      pc   = pc + 32'd4;
      drive(v, w, pc, ordy, fl);
      #1;
      n_checks++;
      if (in_ready !== (!mvld || ordy)) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, (!mvld || ordy));
      end
      if (fl) mvld = 1'b0;
      else if (v && (!mvld || ordy)) begin
        held = ref_decode(w, pc);
        mvld = 1'b1;
      end else if (ordy) mvld = 1'b0;
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_alu_ops();
    test_branch();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
